// File: rtl/axis_requantizer.sv
// Requantises signed FIR accumulator beats: shift, optional round, offset/clamp to OUT_WIDTH.
// Latency: two registered stages (input-side stage 1, output register); one beat per cycle.
// Backpressure: both stages advance together only when the output register is empty or being drained.
//
// Ports: s00_axis_* slave stream (signed samples, tlast), m00_axis_* master stream
// (quantised samples, tlast, constant tstrb), shift = runtime extra shift,
// sat_clr / sat_count = saturating count of clamped output beats.
module axis_requantizer #(
    parameter int IN_WIDTH      = 32,
    parameter int OUT_WIDTH     = 8,
    parameter int M_TDATA_WIDTH = 32,
    parameter int BASE_SHIFT    = 12,
    parameter int ROUND         = 1,
    parameter int OUT_SIGNED    = 0,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                         s00_axis_aclk,
    input  logic                         s00_axis_areset,
    input  logic [IN_WIDTH-1:0]          s00_axis_tdata,
    input  logic                         s00_axis_tvalid,
    input  logic                         s00_axis_tlast,
    output logic                         s00_axis_tready,
    output logic [M_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic                         m00_axis_tvalid,
    output logic                         m00_axis_tlast,
    output logic [M_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
    input  logic                         m00_axis_tready,
    input  logic [3:0]                   shift,
    input  logic                         sat_clr,
    output logic [CNT_WIDTH-1:0]         sat_count
);
    // Internal arithmetic is one bit wider than the input so the rounding add cannot overflow.
    localparam int TW = IN_WIDTH + 1;
    localparam logic signed [TW-1:0] SAT_HI = TW'((64'd1 << (OUT_WIDTH - 1)) - 64'd1);
    localparam logic signed [TW-1:0] SAT_LO = ~SAT_HI;

    logic                    en;
    logic                    accept;
    logic                    in_pkt_q;
    logic [3:0]              held_shift_q;
    logic [3:0]              eff_shift;
    logic [TW-1:0]           t_amt;
    logic signed [TW-1:0]    x_ext;
    logic signed [TW-1:0]    rnd;
    logic signed [TW-1:0]    sum;
    logic signed [TW-1:0]    s1_dat_d;

    logic                    s1_vld_q;
    logic                    s1_last_q;
    logic signed [TW-1:0]    s1_dat_q;

    logic [OUT_WIDTH-1:0]    clamp_d;
    logic                    sat_d;
    logic [M_TDATA_WIDTH-1:0] out_dat_d;

    logic                    m_vld_q;
    logic                    m_last_q;
    logic [M_TDATA_WIDTH-1:0] m_dat_q;
    logic [CNT_WIDTH-1:0]    sat_cnt_q;

    assign en              = !m_vld_q || m00_axis_tready;
    assign s00_axis_tready = en;
    assign accept          = s00_axis_tvalid && en;

    // Shift is frozen for the remainder of a packet once its first beat is taken.
    assign eff_shift = in_pkt_q ? held_shift_q : shift;
    assign t_amt     = TW'(BASE_SHIFT) + TW'(eff_shift);
    assign x_ext     = {s00_axis_tdata[IN_WIDTH-1], s00_axis_tdata};

    always_comb begin
        rnd = '0;
        if (ROUND != 0 && t_amt != '0 && t_amt < TW'(TW))
            rnd = TW'(1) << (t_amt - TW'(1));
    end

    assign sum = x_ext + rnd;

    always_comb begin
        s1_dat_d = sum >>> t_amt;
        // Shifting everything out leaves only the sign of the sample.
        if (t_amt >= TW'(IN_WIDTH))
            s1_dat_d = {TW{x_ext[TW-1]}};
    end

    // Clamp in the two's-complement domain; offset-binary is the same value with the MSB flipped.
    always_comb begin
        sat_d   = 1'b0;
        clamp_d = s1_dat_q[OUT_WIDTH-1:0];
        if (s1_dat_q > SAT_HI) begin
            clamp_d = SAT_HI[OUT_WIDTH-1:0];
            sat_d   = 1'b1;
        end else if (s1_dat_q < SAT_LO) begin
            clamp_d = SAT_LO[OUT_WIDTH-1:0];
            sat_d   = 1'b1;
        end
    end

    always_comb begin
        if (OUT_SIGNED != 0)
            out_dat_d = M_TDATA_WIDTH'(signed'(clamp_d));
        else
            out_dat_d = M_TDATA_WIDTH'({~clamp_d[OUT_WIDTH-1], clamp_d[OUT_WIDTH-2:0]});
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            in_pkt_q     <= 1'b0;
            held_shift_q <= '0;
            s1_vld_q     <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_dat_q     <= '0;
            m_vld_q      <= 1'b0;
            m_last_q     <= 1'b0;
            m_dat_q      <= '0;
        end else begin
            if (accept) begin
                held_shift_q <= eff_shift;
                in_pkt_q     <= !s00_axis_tlast;
            end
            // Bubbles travel through as invalid slots rather than being squeezed out.
            if (en) begin
                s1_vld_q  <= accept;
                s1_last_q <= s00_axis_tlast;
                s1_dat_q  <= s1_dat_d;
                m_vld_q   <= s1_vld_q;
                m_last_q  <= s1_last_q;
                m_dat_q   <= out_dat_d;
            end
        end
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset)
            sat_cnt_q <= '0;
        else if (sat_clr)
            sat_cnt_q <= '0;
        else if (en && s1_vld_q && sat_d && !(&sat_cnt_q))
            sat_cnt_q <= sat_cnt_q + CNT_WIDTH'(1);
    end

    assign m00_axis_tdata  = m_dat_q;
    assign m00_axis_tvalid = m_vld_q;
    assign m00_axis_tlast  = m_last_q;
    assign m00_axis_tstrb  = '1;
    assign sat_count       = sat_cnt_q;
endmodule
